// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: takes WIDTH-bit words over valid/ready and
// emits one bit per enabled clock on x, streaming back-to-back words without gaps.
module seq_bit_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             bit_en,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             frame_done,
   output logic             state_dbg
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SHIFT = 1'b1;

   logic [0:0]       state;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_shifted;
   logic [CW-1:0]    cnt;
   logic             last;
   logic             accept;

   // Handshake: a word moves on a rising edge where din_valid and din_ready are
   // both high. din_ready is high whenever idle, and also while the last bit of
   // the current word is being consumed, so the next word loads with no bubble.
   assign last       = (state == S_SHIFT) && (cnt == CNT_LAST);
   assign din_ready  = (state == S_IDLE) || (last && bit_en);
   assign accept     = din_valid && din_ready;

   assign busy       = (state == S_SHIFT);
   assign x_valid    = (state == S_SHIFT) && bit_en;
   assign frame_done = last && bit_en;
   assign state_dbg  = state[0];

   always_comb begin
      sr_shifted = '0;
      if (MSB_FIRST) sr_shifted = {sr[WIDTH-2:0], 1'b0};
      else           sr_shifted = {1'b0, sr[WIDTH-1:1]};
   end

   always_comb begin
      x = 1'b0;
      if (state == S_SHIFT) x = MSB_FIRST ? sr[WIDTH-1] : sr[0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         sr    <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  sr    <= din;
                  cnt   <= '0;
                  state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (bit_en) begin
                  if (last) begin
                     if (accept) begin
                        sr  <= din;
                        cnt <= '0;
                     end else begin
                        sr    <= '0;
                        cnt   <= '0;
                        state <= S_IDLE;
                     end
                  end else begin
                     sr  <= sr_shifted;
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               sr    <= '0;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: one MSB-first and one LSB-first instance share
// the stimulus and are checked every cycle against a word/bits-remaining model.
module tb_seq_bit_serializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [W-1:0] din = '0;
   logic         din_valid = 1'b0;
   logic         bit_en = 1'b0;

   logic din_ready_m, x_m, x_valid_m, busy_m, frame_done_m, state_dbg_m;
   logic din_ready_l, x_l, x_valid_l, busy_l, frame_done_l, state_dbg_l;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   logic [31:0] obs_m, obs_l;
   int nv, first_v, last_v, fd_cnt, fd_last, fd_gap;

   // Model: the word in flight and how many of its bits are still to go
   logic [W-1:0] m_word;
   int           m_rem;

   always #5 clk = ~clk;

   seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
      .din_ready(din_ready_m), .bit_en(bit_en), .x(x_m), .x_valid(x_valid_m),
      .busy(busy_m), .frame_done(frame_done_m), .state_dbg(state_dbg_m));

   seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
      .din_ready(din_ready_l), .bit_en(bit_en), .x(x_l), .x_valid(x_valid_l),
      .busy(busy_l), .frame_done(frame_done_l), .state_dbg(state_dbg_l));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic m_ready();
      return (m_rem == 0) || (m_rem == 1 && bit_en);
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_rem  <= 0;
         m_word <= '0;
      end else if (m_ready() && din_valid) begin
         m_word <= din;
         m_rem  <= W;
      end else if (m_rem > 0 && bit_en) begin
         m_rem <= m_rem - 1;
      end
   end

   always @(negedge clk) begin
      logic e_busy, e_xm, e_xl, e_xv, e_fd, e_rdy;
      cyc++;
      if (chk_en) begin
         e_busy = (m_rem > 0);
         e_xm   = e_busy ? m_word[m_rem-1] : 1'b0;
         e_xl   = e_busy ? m_word[W-m_rem] : 1'b0;
         e_xv   = e_busy && bit_en;
         e_fd   = (m_rem == 1) && bit_en;
         e_rdy  = m_ready();
         chk("x_m",          32'(x_m),          32'(e_xm));
         chk("x_l",          32'(x_l),          32'(e_xl));
         chk("x_valid_m",    32'(x_valid_m),    32'(e_xv));
         chk("x_valid_l",    32'(x_valid_l),    32'(e_xv));
         chk("busy_m",       32'(busy_m),       32'(e_busy));
         chk("busy_l",       32'(busy_l),       32'(e_busy));
         chk("state_dbg_m",  32'(state_dbg_m),  32'(e_busy));
         chk("frame_done_m", 32'(frame_done_m), 32'(e_fd));
         chk("frame_done_l", 32'(frame_done_l), 32'(e_fd));
         chk("din_ready_m",  32'(din_ready_m),  32'(e_rdy));
         chk("din_ready_l",  32'(din_ready_l),  32'(e_rdy));
         if (x_valid_m) begin
            obs_m = {obs_m[30:0], x_m};
            nv++;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
         end
         if (x_valid_l) obs_l = {obs_l[30:0], x_l};
         if (frame_done_m) begin
            if (fd_cnt > 0) fd_gap = cyc - fd_last;
            fd_last = cyc;
            fd_cnt++;
         end
      end
   end

   task automatic clear_obs();
      obs_m = '0; obs_l = '0; nv = 0; first_v = -1; last_v = -1;
      fd_cnt = 0; fd_last = 0; fd_gap = 0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Presents w and returns #1 after the edge that accepts it; din_valid stays high
   task automatic send_word(input logic [W-1:0] w);
      logic r;
      bit   done;
      din = w;
      din_valid = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 64 && !done; i++) begin
         @(negedge clk);
         r = din_ready_m;
         @(posedge clk);
         #1;
         if (r) done = 1'b1;
      end
      if (!done) chk("accept_timeout", 32'(done), 32'(1));
   endtask

   initial begin
      clear_obs();
      chk_en = 1'b1;
      reset_n = 1'b0;
      cycles(3);
      reset_n = 1'b1;

      // Reset then idle
      cycles(4);
      chk("idle_ready", 32'(din_ready_m), 32'(1));
      chk("idle_busy",  32'(busy_m),      32'(0));
      chk("idle_x",     32'(x_m),         32'(0));
      chk("idle_nv",    32'(nv),          32'(0));

      // Single word 8'hBB
      bit_en = 1'b1;
      clear_obs();
      send_word(8'hBB);
      din_valid = 1'b0;
      cycles(10);
      chk("bb_stream_msb", obs_m, 32'h0000_00BB);
      chk("bb_stream_lsb", obs_l, 32'h0000_00DD);
      chk("bb_nbits",      32'(nv), 32'(8));
      chk("bb_fd_count",   32'(fd_cnt), 32'(1));
      chk("bb_end_idle",   32'(busy_m), 32'(0));

      // Back-to-back 8'hB0, 8'h0B
      clear_obs();
      send_word(8'hB0);
      send_word(8'h0B);
      din_valid = 1'b0;
      cycles(10);
      chk("b2b_stream",    obs_m, 32'h0000_B00B);
      chk("b2b_nbits",     32'(nv), 32'(16));
      chk("b2b_contig",    32'(last_v - first_v), 32'(15));
      chk("b2b_fd_count",  32'(fd_cnt), 32'(2));
      chk("b2b_fd_gap",    32'(fd_gap), 32'(8));

      // Pacing: 8'hA5 with bit_en alternating 1,0
      clear_obs();
      send_word(8'hA5);
      din_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         bit_en = (i % 2 == 0);
         cycles(1);
      end
      bit_en = 1'b1;
      cycles(3);
      chk("pace_stream",   obs_m, 32'h0000_00A5);
      chk("pace_nbits",    32'(nv), 32'(8));
      chk("pace_span",     32'(last_v - first_v), 32'(14));
      chk("pace_fd_count", 32'(fd_cnt), 32'(1));

      // LSB-first 8'h0D
      clear_obs();
      send_word(8'h0D);
      din_valid = 1'b0;
      cycles(10);
      chk("lsb_stream",    obs_l, 32'h0000_00B0);
      chk("lsb_msb_twin",  obs_m, 32'h0000_000D);

      // Async reset after three bits of 8'hFF
      clear_obs();
      send_word(8'hFF);
      din_valid = 1'b0;
      cycles(3);
      #1;
      reset_n = 1'b0;
      #1;
      chk("rst_x",          32'(x_m),          32'(0));
      chk("rst_x_valid",    32'(x_valid_m),    32'(0));
      chk("rst_busy",       32'(busy_m),       32'(0));
      chk("rst_frame_done", 32'(frame_done_m), 32'(0));
      chk("rst_ready",      32'(din_ready_m),  32'(1));
      chk("rst_busy_l",     32'(busy_l),       32'(0));
      chk("rst_nbits",      32'(nv),           32'(3));
      cycles(2);
      reset_n = 1'b1;
      cycles(1);
      chk("rst_fd_count",   32'(fd_cnt),       32'(0));
      clear_obs();
      send_word(8'h96);
      din_valid = 1'b0;
      cycles(10);
      chk("post_rst_msb",   obs_m, 32'h0000_0096);
      chk("post_rst_lsb",   obs_l, 32'h0000_0069);
      chk("post_rst_fd",    32'(fd_cnt), 32'(1));

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/seq_bit_serializer.md
# seq_bit_serializer

Parallel-to-serial front end for the FSM sequence-detector stages. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per enabled clock on `x`, with `x_valid` qualifying each bit. It sits directly upstream of the pattern detectors (e.g. the 1011 Moore detector) and drives their serial `x` input. Back-to-back words stream with no idle bit between them.

## Interface
- `WIDTH`, 8: word width in bits; ≥ 2.
- `MSB_FIRST`, 1: 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.

- `clk`  in  1  single clock, rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `din`  in  WIDTH  parallel word; sampled on an accept edge.
- `din_valid`  in  1  `din` holds a word.
- `din_ready`  out  1  block can take a word this cycle.
- `bit_en`  in  1  pacing strobe; a bit is consumed only on edges with `bit_en`=1.
- `x`  out  1  current serial bit.
- `x_valid`  out  1  `x` is a real data bit this cycle.
- `busy`  out  1  a word is loaded and not fully shifted.
- `frame_done`  out  1  single-cycle pulse on the cycle the last bit of a word is consumed.

## Operation
- Two states: IDLE, SHIFT. Registers: `state`, shift register `sr[WIDTH-1:0]`, bit counter `cnt` (clog2(WIDTH) bits, 0..WIDTH-1).
- Accept = `din_valid & din_ready` at a rising edge.
- `last` = (state==SHIFT) & (cnt==WIDTH-1).
- `din_ready` = (state==IDLE) | (`last` & `bit_en`). Combinational.
- IDLE: on accept, load `sr`<=`din`, `cnt`<=0, go SHIFT. No accept: stay IDLE.
- SHIFT, `bit_en`=0: hold everything. `x` stays stable.
- SHIFT, `bit_en`=1, not `last`: shift `sr` one position toward the output end (left if MSB_FIRST, else right), fill 0, `cnt`<=`cnt`+1.
- SHIFT, `bit_en`=1, `last`: if accept, reload `sr`/`cnt` and stay SHIFT (zero-bubble). Otherwise go IDLE, `sr`<=0, `cnt`<=0.
- `x` = `sr[WIDTH-1]` (MSB_FIRST=1) or `sr[0]` (MSB_FIRST=0) in SHIFT. `x` = 0 in IDLE.
- `x_valid` = (state==SHIFT) & `bit_en`.
- `busy` = (state==SHIFT).
- `frame_done` = `last` & `bit_en`.
- `din` is ignored when no accept occurs. A `din_valid` held while not ready is neither lost nor duplicated; it is taken on the next ready cycle.
- Counter never wraps past WIDTH-1. An accept always resets `cnt` to 0.

## Timing
- Reset (`reset_n`=0, asynchronous): state IDLE, `sr`=0, `cnt`=0. Immediately `x`=0, `x_valid`=0, `busy`=0, `frame_done`=0, `din_ready`=1.
- Reset mid-word: the word is discarded. No `frame_done` is produced. Resume in IDLE after release.
- Latency: accept at edge N. First bit appears on `x` in cycle N+1, valid if `bit_en`=1.
- Throughput: with `bit_en` held at 1, one word per WIDTH cycles, and `x_valid` is continuous across words.
- `din_ready`, `x_valid` and `frame_done` are combinational from `bit_en`. `x` and `busy` are purely registered.
- The downstream detector samples `x` only when `x_valid`=1. With `bit_en` tied high, `x` maps 1:1 onto the detector's per-clock input.

## Test plan
- Reset then idle: `reset_n` low 3 cycles, release, `din_valid`=0 → `din_ready`=1, `busy`=0, `x`=0, `x_valid`=0 throughout.
- Single word, MSB_FIRST=1, WIDTH=8, `bit_en`=1, `din`=8'hBB → `x` = 1,0,1,1,1,0,1,1 on cycles N+1..N+8. `frame_done` pulses only at N+8. IDLE at N+9.
- Back-to-back: 8'hB0 then 8'h0B with `din_valid` held high → 16 contiguous `x_valid` bits 10110000 00001011. `din_ready` is high only in the cycles the last bit of each word is consumed (and in IDLE). Two `frame_done` pulses, 8 cycles apart.
- Pacing: 8'hA5 with `bit_en` alternating 1,0 → 8 valid bits 10100101 over 16 cycles. `x` is unchanged during `bit_en`=0 cycles. `frame_done` fires once.
- LSB-first (MSB_FIRST=0), `din`=8'h0D → `x` = 1,0,1,1,0,0,0,0.
- Async reset mid-word: assert `reset_n`=0 between clock edges after 3 bits of 8'hFF → outputs reach reset values without waiting for a clock edge. No `frame_done`. A new word after release shifts from bit 0 correctly.
